pellet_map_writer: RTL and testbench
====================================

Name: pellet_map_writer

Overview:
- Sole write-side owner of the 32x32x1 pellet RAM that the pellet renderer reads through its 5-bit cell coordinates.
- At level start it copies the maze layout ROM into the RAM.
- During play it clears a pellet when Pac-Man's cell reports an eat.
- It tracks the pellets remaining and flags power-up consumption and level clear to the game FSM.

Parameters:
- CNT_W, 10, width of the pellet_count register (max 1024 cells).
- PWR_X0 / PWR_X1, 2 / 27, power-up cell columns.
- PWR_Y0 / PWR_Y1, 4 / 24, power-up cell rows.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- start_init  in  1  one-cycle pulse: begin layout copy
- eat_req  in  1  one-cycle pulse: Pac-Man entered cell (eat_x, eat_y)
- eat_x  in  5  cell column
- eat_y  in  5  cell row
- rom_x  out  5  layout ROM column address
- rom_y  out  5  layout ROM row address
- rom_din  in  1  layout ROM data; registered, 1-cycle latency
- rd_x  out  5  pellet RAM read port B column address
- rd_y  out  5  pellet RAM read port B row address
- rd_din  in  1  pellet RAM port B data; 1-cycle latency
- wr_x  out  5  pellet RAM write column address
- wr_y  out  5  pellet RAM write row address
- wr_en  out  1  pellet RAM write strobe
- wr_data  out  1  pellet RAM write data
- ready  out  1  high in IDLE; eat_req and start_init are accepted only then
- pellet_eaten  out  1  one-cycle pulse when a pellet is cleared
- power_eaten  out  1  one-cycle pulse when the cleared pellet is a power-up cell
- level_clear  out  1  level-clear flag (see Behaviour)
- pellet_count  out  CNT_W  pellets remaining

Behaviour:
- Reset (async, reset_n=0): state IDLE; all address outputs 0; wr_en, pellet_eaten, power_eaten and level_clear 0; pellet_count 0. Reset mid-sweep or mid-eat aborts immediately; no further writes occur.
- States: IDLE, INIT, INIT_LAST, EAT_RD, EAT_WR.
- IDLE:
  - start_init=1 -> INIT with sweep address (0,0), pellet_count cleared, level_clear cleared.
  - Otherwise eat_req=1 -> EAT_RD, latching eat_x/eat_y.
  - If both are high, start_init wins and the eat is dropped.
- INIT (pipelined sweep):
  - Each cycle drive rom_x/rom_y = sweep address, then increment x; on x wrap (31->0) increment y.
  - One cycle later, write the previous address with wr_data = rom_din, forced to 0 when x or y is 0 or 31 (border cells).
  - When wr_data=1, pellet_count += 1.
  - After address (31,31) is issued -> INIT_LAST, which performs the final write -> IDLE.
  - Sweep is exactly 1025 cycles from start_init acceptance to ready rising. Addresses are row-major.
- EAT_RD: drive rd_x/rd_y = latched cell; no write -> EAT_WR.
- EAT_WR: sample rd_din.
  - If 1: assert wr_en with wr_data=0 at the latched cell; decrement pellet_count; pulse pellet_eaten; pulse power_eaten if (x∈{PWR_X0,PWR_X1}) and (y∈{PWR_Y0,PWR_Y1}).
  - If 0: no write, no pulses.
  - Either way -> IDLE.
  - Eat latency: 2 cycles from request to write/pulse.
- eat_req or start_init while not ready: ignored (not queued).
- pellet_count never underflows: a decrement at 0 cannot occur, because rd_din=1 implies count ≥ 1; an assertion checks this.
- level_clear:
  - Set in the EAT_WR cycle where the count goes 1->0, as a registered value visible the next cycle.
  - Stays high until the next start_init.
  - Never set by the sweep, even if the layout has zero pellets.
- wr_en is high only in INIT/INIT_LAST write cycles and qualifying EAT_WR cycles. wr_x/wr_y hold the last value otherwise.
- Sweep and eat are mutually exclusive, so RAM port B and the write port never conflict with this block. The renderer's port A is unaffected.

Decomposition:
- Shared package (pacman_defs): CELL_W=5, GRID_MAX=31, power-up cell constants (shared with the renderer's isPowerUp decode), and the state encoding localparams.
- One natural sub-module, pellet_counter (load-clear / inc / dec, zero-detect to level_clear). All other logic stays in the top FSM.

Test Plan:
- Reset mid-sweep: assert reset_n=0 at cycle 300 of INIT -> wr_en=0 immediately, count=0, ready=1 after release; a new start_init then completes a full 1025-cycle sweep.
- Full sweep: ROM holding 244 pellets plus 1s on the border -> exactly 1024 writes in row-major order, all border writes 0, pellet_count=244, level_clear=0, ready rises at cycle 1025.
- Eat a normal pellet at (5,4) with RAM=1 -> at cycle +2: wr_en=1 at (5,4) with wr_data=0, pellet_eaten=1, power_eaten=0, count decrements by 1. Repeat the eat -> no write, no pulse.
- Eat a power-up at (27,24) -> pellet_eaten=1 and power_eaten=1 in the same cycle. Eat at (27,23) -> power_eaten=0.
- Eat the last pellet with count=1 -> count=0, level_clear=1 the next cycle and held. start_init -> level_clear=0.
- Contention: eat_req during INIT is ignored (no extra write). start_init and eat_req in the same IDLE cycle -> sweep starts and the eat is dropped.

Source files
------------

// File: rtl/pacman_defs.sv
`default_nettype none
// ============================================================================
// Module   : pacman_defs (package)
// Brief    : Maze grid constants, power-up cells and pellet writer states.
// Revision : 1.0 - initial release
// ============================================================================
package pacman_defs;

    localparam int CELL_W   = 5;
    localparam int GRID_MAX = 31;

    // Power-up cell decode, shared with the renderer's isPowerUp logic
    localparam int PWR_COL0 = 2;
    localparam int PWR_COL1 = 27;
    localparam int PWR_ROW0 = 4;
    localparam int PWR_ROW1 = 24;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT      = 3'd1;
    localparam logic [2:0] ST_INIT_LAST = 3'd2;
    localparam logic [2:0] ST_EAT_RD    = 3'd3;
    localparam logic [2:0] ST_EAT_WR    = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        INIT      = ST_INIT,
        INIT_LAST = ST_INIT_LAST,
        EAT_RD    = ST_EAT_RD,
        EAT_WR    = ST_EAT_WR
    } state_t;

    function automatic logic is_border(input logic [CELL_W-1:0] x,
                                       input logic [CELL_W-1:0] y);
        return (x == '0) || (x == CELL_W'(GRID_MAX)) ||
               (y == '0) || (y == CELL_W'(GRID_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pellet_counter.sv
`default_nettype none
// ============================================================================
// Module   : pellet_counter
// Brief    : Pellets-remaining counter with sticky level-clear on 1->0.
// Revision : 1.0 - initial release
// ============================================================================
module pellet_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             level_clear
);

    logic [CNT_W-1:0] r_count;
    logic             r_level_clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count       <= '0;
            r_level_clear <= 1'b0;
        end else if (clr) begin
            r_count       <= '0;
            r_level_clear <= 1'b0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end else if (dec) begin
            r_count <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
                r_level_clear <= 1'b1;
            end
        end
    end

    // A set pellet read back from RAM implies at least one pellet is counted
    a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
                                      dec |-> (r_count != '0));

    assign count       = r_count;
    assign level_clear = r_level_clear;

endmodule
`default_nettype wire

// File: rtl/pellet_map_writer.sv
`default_nettype none
// ============================================================================
// Module   : pellet_map_writer
// Brief    : Sole writer of the 32x32 pellet RAM: layout copy and pellet eat.
// Revision : 1.0 - initial release
// ============================================================================
module pellet_map_writer
    import pacman_defs::*;
#(
    parameter int CNT_W  = 10,
    parameter int PWR_X0 = PWR_COL0,
    parameter int PWR_X1 = PWR_COL1,
    parameter int PWR_Y0 = PWR_ROW0,
    parameter int PWR_Y1 = PWR_ROW1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_init,
    input  logic              eat_req,
    input  logic [CELL_W-1:0] eat_x,
    input  logic [CELL_W-1:0] eat_y,
    output logic [CELL_W-1:0] rom_x,
    output logic [CELL_W-1:0] rom_y,
    input  logic              rom_din,
    output logic [CELL_W-1:0] rd_x,
    output logic [CELL_W-1:0] rd_y,
    input  logic              rd_din,
    output logic [CELL_W-1:0] wr_x,
    output logic [CELL_W-1:0] wr_y,
    output logic              wr_en,
    output logic              wr_data,
    output logic              ready,
    output logic              pellet_eaten,
    output logic              power_eaten,
    output logic              level_clear,
    output logic [CNT_W-1:0]  pellet_count
);

    localparam int ADDR_W = 2 * CELL_W;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_sweep;
    logic [ADDR_W-1:0]   w_prev;
    logic [CELL_W-1:0]   r_cell_x;
    logic [CELL_W-1:0]   r_cell_y;
    logic [CELL_W-1:0]   r_wr_x;
    logic [CELL_W-1:0]   r_wr_y;
    logic                w_accept_init;
    logic                w_accept_eat;
    logic                w_sweep_wr;
    logic                w_sweep_data;
    logic                w_eat_hit;
    logic                w_is_power;

    assign w_accept_init = (r_state == IDLE) && start_init;
    assign w_accept_eat  = (r_state == IDLE) && !start_init && eat_req;

    // ROM data arriving now belongs to the address issued one cycle ago
    assign w_prev       = r_sweep - ADDR_W'(1);
    assign w_sweep_wr   = ((r_state == INIT) && (r_sweep != '0)) || (r_state == INIT_LAST);
    assign w_sweep_data = rom_din && !is_border(w_prev[CELL_W-1:0], w_prev[ADDR_W-1:CELL_W]);

    assign w_eat_hit  = (r_state == EAT_WR) && rd_din;
    assign w_is_power = ((r_cell_x == CELL_W'(PWR_X0)) || (r_cell_x == CELL_W'(PWR_X1))) &&
                        ((r_cell_y == CELL_W'(PWR_Y0)) || (r_cell_y == CELL_W'(PWR_Y1)));

    always_comb begin
        w_next  = r_state;
        wr_en   = 1'b0;
        wr_data = 1'b0;
        wr_x    = r_wr_x;
        wr_y    = r_wr_y;

        case (r_state)
            IDLE: begin
                if (start_init) begin
                    w_next = INIT;
                end else if (eat_req) begin
                    w_next = EAT_RD;
                end
            end
            INIT: begin
                if (r_sweep == '1) begin
                    w_next = INIT_LAST;
                end
            end
            INIT_LAST: w_next = IDLE;
            EAT_RD:    w_next = EAT_WR;
            EAT_WR:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase

        if (w_sweep_wr) begin
            wr_en   = 1'b1;
            wr_data = w_sweep_data;
            wr_x    = w_prev[CELL_W-1:0];
            wr_y    = w_prev[ADDR_W-1:CELL_W];
        end else if (w_eat_hit) begin
            wr_en   = 1'b1;
            wr_data = 1'b0;
            wr_x    = r_cell_x;
            wr_y    = r_cell_y;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_sweep  <= '0;
            r_cell_x <= '0;
            r_cell_y <= '0;
            r_wr_x   <= '0;
            r_wr_y   <= '0;
        end else begin
            r_state <= w_next;
            r_wr_x  <= wr_x;
            r_wr_y  <= wr_y;
            if (w_accept_init) begin
                r_sweep <= '0;
            end else if (r_state == INIT) begin
                r_sweep <= r_sweep + ADDR_W'(1);
            end
            if (w_accept_eat) begin
                r_cell_x <= eat_x;
                r_cell_y <= eat_y;
            end
        end
    end

    pellet_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (w_accept_init),
        .inc         (w_sweep_wr && w_sweep_data),
        .dec         (w_eat_hit),
        .count       (pellet_count),
        .level_clear (level_clear)
    );

    assign rom_x        = r_sweep[CELL_W-1:0];
    assign rom_y        = r_sweep[ADDR_W-1:CELL_W];
    assign rd_x         = r_cell_x;
    assign rd_y         = r_cell_y;
    assign ready        = (r_state == IDLE);
    assign pellet_eaten = w_eat_hit;
    assign power_eaten  = w_eat_hit && w_is_power;

endmodule
`default_nettype wire

// File: tb/tb_pellet_map_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pellet_map_writer
// Brief    : Self-checking bench with ROM/RAM models and a cell-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pellet_map_writer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_init = 1'b0;
    logic       eat_req = 1'b0;
    logic [4:0] eat_x = '0;
    logic [4:0] eat_y = '0;
    logic [4:0] rom_x, rom_y, rd_x, rd_y, wr_x, wr_y;
    logic       rom_din, rd_din, wr_en, wr_data;
    logic       ready, pellet_eaten, power_eaten, level_clear;
    logic [9:0] pellet_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pellet_map_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_init   (start_init),
        .eat_req      (eat_req),
        .eat_x        (eat_x),
        .eat_y        (eat_y),
        .rom_x        (rom_x),
        .rom_y        (rom_y),
        .rom_din      (rom_din),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_din       (rd_din),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .ready        (ready),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .level_clear  (level_clear),
        .pellet_count (pellet_count)
    );

    // Registered layout ROM and pellet RAM (1-cycle read latency)
    bit   rom_mem [1024];
    bit   ram_mem [1024];
    logic rom_q = 1'b0;
    logic rd_q  = 1'b0;
    assign rom_din = rom_q;
    assign rd_din  = rd_q;

    always @(posedge clk) begin
        rom_q <= rom_mem[{rom_y, rom_x}];
        rd_q  <= ram_mem[{rd_y, rd_x}];
        if (wr_en === 1'b1) ram_mem[{wr_y, wr_x}] <= wr_data;
    end

    typedef struct packed { logic [9:0] a; logic d; } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        wr_t w;
        if (wr_en === 1'b1) begin
            w.a = {wr_y, wr_x};
            w.d = wr_data;
            wlog.push_back(w);
        end
    end

    // Reference model: what the RAM should hold and what the block should report
    bit ref_ram [1024];
    int ref_count = 0;
    bit ref_lc    = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit layout_bit(input int i);
        int x = i % 32;
        int y = i / 32;
        return rom_mem[i] && (x != 0) && (x != 31) && (y != 0) && (y != 31);
    endfunction

    task automatic do_sweep(input string tag, input bit same_eat, input bit mid_eat);
        int k = 0;
        int nord = 0;
        int ndata = 0;
        int nbord = 0;
        int exp_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            ref_ram[i] = layout_bit(i);
            if (ref_ram[i]) exp_cnt++;
        end
        @(negedge clk);
        wlog.delete();
        start_init = 1'b1;
        if (same_eat) begin
            eat_req = 1'b1; eat_x = 5'd5; eat_y = 5'd4;
        end
        @(negedge clk);
        start_init = 1'b0;
        eat_req    = 1'b0;
        check1({tag, " lc_cleared"}, level_clear, 1'b0);
        checkn({tag, " count_cleared"}, int'(pellet_count), 0);
        while (ready !== 1'b1 && k < 2000) begin
            if (mid_eat && k == 100) begin
                eat_req = 1'b1; eat_x = 5'd10; eat_y = 5'd3;
            end else begin
                eat_req = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        eat_req = 1'b0;
        checkn({tag, " sweep_cycles"}, k, 1025);
        checkn({tag, " write_count"}, wlog.size(), 1024);
        foreach (wlog[i]) begin
            int x = int'(wlog[i].a) % 32;
            int y = int'(wlog[i].a) / 32;
            if (int'(wlog[i].a) != i) nord++;
            if (i < 1024 && wlog[i].d != layout_bit(i)) ndata++;
            if ((x == 0 || x == 31 || y == 0 || y == 31) && wlog[i].d) nbord++;
        end
        checkn({tag, " order_errs"}, nord, 0);
        checkn({tag, " data_errs"}, ndata, 0);
        checkn({tag, " border_errs"}, nbord, 0);
        checkn({tag, " count"}, int'(pellet_count), exp_cnt);
        check1({tag, " lc_after"}, level_clear, 1'b0);
        ref_count = exp_cnt;
        ref_lc    = 1'b0;
    endtask

    task automatic do_eat(input string tag, input int x, input int y, input bit hit,
                          input bit pwr, input int cnt, input bit lc);
        @(negedge clk);
        check1({tag, " ready"}, ready, 1'b1);
        eat_req = 1'b1;
        eat_x   = 5'(x);
        eat_y   = 5'(y);
        @(negedge clk);
        eat_req = 1'b0;
        check1({tag, " rd_nowrite"}, wr_en, 1'b0);
        @(negedge clk);
        check1({tag, " wr_en"}, wr_en, hit);
        check1({tag, " pellet_eaten"}, pellet_eaten, hit);
        check1({tag, " power_eaten"}, power_eaten, pwr);
        if (hit) begin
            checkn({tag, " wr_x"}, int'(wr_x), x);
            checkn({tag, " wr_y"}, int'(wr_y), y);
            check1({tag, " wr_data"}, wr_data, 1'b0);
        end
        @(negedge clk);
        check1({tag, " pulse_end"}, pellet_eaten, 1'b0);
        checkn({tag, " count"}, int'(pellet_count), cnt);
        check1({tag, " level_clear"}, level_clear, lc);
        check1({tag, " back_idle"}, ready, 1'b1);
    endtask

    task automatic eat_model(input string tag, input int x, input int y);
        int  idx = y * 32 + x;
        bit  hit = ref_ram[idx];
        bit  pwr = hit && (x == 2 || x == 27) && (y == 4 || y == 24);
        if (hit) begin
            ref_ram[idx] = 1'b0;
            ref_count--;
            if (ref_count == 0) ref_lc = 1'b1;
        end
        do_eat(tag, x, y, hit, pwr, ref_count, ref_lc);
    endtask

    typedef struct { int x; int y; bit hit; bit pwr; } eat_vec_t;
    eat_vec_t tbl [11];

    initial begin
        int n;
        int cnt;
        int x;
        int y;

        tbl[0]  = '{5, 4, 1'b1, 1'b0};
        tbl[1]  = '{5, 4, 1'b0, 1'b0};
        tbl[2]  = '{27, 24, 1'b1, 1'b1};
        tbl[3]  = '{27, 23, 1'b1, 1'b0};
        tbl[4]  = '{2, 4, 1'b1, 1'b1};
        tbl[5]  = '{2, 24, 1'b0, 1'b0};
        tbl[6]  = '{0, 0, 1'b0, 1'b0};
        tbl[7]  = '{31, 5, 1'b0, 1'b0};
        tbl[8]  = '{3, 9, 1'b0, 1'b0};
        tbl[9]  = '{2, 9, 1'b1, 1'b0};
        tbl[10] = '{27, 4, 1'b1, 1'b1};

        // Layout: border all 1s; 244 interior pellets = rows 1..8, (27,23), (27,24), (1,9), (2,9)
        for (int i = 0; i < 1024; i++) begin
            x = i % 32; y = i / 32;
            rom_mem[i] = (x == 0 || x == 31 || y == 0 || y == 31);
            ram_mem[i] = 1'b0;
        end
        rom_mem[24 * 32 + 27] = 1'b1;
        rom_mem[23 * 32 + 27] = 1'b1;
        n = 2;
        for (int i = 0; i < 1024 && n < 244; i++) begin
            x = i % 32; y = i / 32;
            if (x != 0 && x != 31 && y != 0 && y != 31 && !rom_mem[i]) begin
                rom_mem[i] = 1'b1;
                n++;
            end
        end

        repeat (3) @(negedge clk);
        check1("reset ready", ready, 1'b1);
        check1("reset wr_en", wr_en, 1'b0);
        checkn("reset count", int'(pellet_count), 0);
        check1("reset lc", level_clear, 1'b0);
        checkn("reset addr", int'({rom_x, rom_y, rd_x, rd_y, wr_x, wr_y}), 0);
        reset_n = 1'b1;

        do_sweep("sweep244", 1'b0, 1'b0);
        checkn("layout_total", ref_count, 244);

        cnt = 244;
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].hit) cnt--;
            do_eat($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].hit, tbl[i].pwr, cnt, 1'b0);
        end

        // Reset in the middle of a sweep
        @(negedge clk);
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
        repeat (299) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check1("midrst wr_en", wr_en, 1'b0);
        checkn("midrst count", int'(pellet_count), 0);
        checkn("midrst addr", int'({rom_x, rom_y, wr_x, wr_y}), 0);
        wlog.delete();
        repeat (3) @(negedge clk);
        checkn("midrst writes", wlog.size(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check1("midrst ready", ready, 1'b1);
        do_sweep("after_rst", 1'b0, 1'b0);

        // Contention: eat during sweep, and eat together with start_init
        do_sweep("mid_eat", 1'b0, 1'b1);
        do_sweep("same_eat", 1'b1, 1'b0);

        // Empty layout never raises level_clear
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'b0;
        do_sweep("empty", 1'b0, 1'b0);
        eat_model("empty_eat", 10, 10);

        // Two pellets: clear the level
        for (int i = 0; i < 1024; i++) rom_mem[i] = (i % 32 == 0) || (i / 32 == 31);
        rom_mem[3 * 32 + 3] = 1'b1;
        rom_mem[8 * 32 + 7] = 1'b1;
        do_sweep("two", 1'b0, 1'b0);
        do_eat("last1", 3, 3, 1'b1, 1'b0, 1, 1'b0);
        do_eat("last0", 7, 8, 1'b1, 1'b0, 0, 1'b1);
        repeat (5) @(negedge clk);
        check1("lc_held", level_clear, 1'b1);
        do_eat("lc_miss", 3, 3, 1'b0, 1'b0, 0, 1'b1);

        // Random layout and random eats against the reference model
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'($urandom);
        do_sweep("rnd_sweep", 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            if (i % 25 == 0) begin
                x = ($urandom & 1) ? 27 : 2;
                y = ($urandom & 1) ? 24 : 4;
            end else begin
                x = $urandom_range(0, 31);
                y = $urandom_range(0, 31);
            end
            eat_model($sformatf("rnd%0d", i), x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
